// File: rtl/slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : slot_allocator
// Purpose  : 32-entry occupancy tracker granting the lowest free slot index
//            and accepting slot releases, one request of each per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module slot_allocator #(
    parameter int NUM_SLOTS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc_req,
    input  logic       free_valid,
    input  logic [5:0] free_id,
    output logic       alloc_gnt,
    output logic       alloc_fail,
    output logic [5:0] alloc_id,
    output logic       free_err,
    output logic [31:0] occupancy,
    output logic [5:0] free_count,
    output logic       full,
    output logic       empty
);

    localparam logic [5:0]  c_none       = 6'(NUM_SLOTS);
    localparam logic [31:0] c_valid_mask = (NUM_SLOTS >= 32) ? 32'hFFFF_FFFF
                                         : ((32'd1 << NUM_SLOTS) - 32'd1);

    logic [31:0] r_occ;
    logic [5:0]  r_free_count;
    logic        r_full;
    logic        r_empty;
    logic        r_alloc_gnt;
    logic        r_alloc_fail;
    logic [5:0]  r_alloc_id;
    logic        r_free_err;

    logic [31:0] w_search_word;
    logic [5:0]  w_search;
    logic        w_gnt;
    logic        w_fail;
    logic        w_free_hit;
    logic        w_free_err;
    logic [31:0] w_occ_nxt;
    logic [5:0]  w_count_nxt;

    // Slots beyond NUM_SLOTS read as occupied so they are never granted.
    assign w_search_word = r_occ | ~c_valid_mask;

    always_comb begin
        w_search = c_none;
        for (int i = 31; i >= 0; i--) begin
            if (!w_search_word[i]) begin
                w_search = 6'(i);
            end
        end
    end

    assign w_gnt      = alloc_req && (w_search != c_none);
    assign w_fail     = alloc_req && (w_search == c_none);
    assign w_free_hit = free_valid && (free_id < c_none) && r_occ[free_id[4:0]];
    assign w_free_err = free_valid && !w_free_hit;

    // A successful release always targets a set bit and a grant a clear one,
    // so the two updates never touch the same slot.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_free_hit) begin
            w_occ_nxt[free_id[4:0]] = 1'b0;
        end
        if (w_gnt) begin
            w_occ_nxt[w_search[4:0]] = 1'b1;
        end
    end

    assign w_count_nxt = r_free_count + {5'd0, w_free_hit} - {5'd0, w_gnt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ        <= 32'd0;
            r_free_count <= c_none;
            r_full       <= (c_none == 6'd0);
            r_empty      <= 1'b1;
            r_alloc_gnt  <= 1'b0;
            r_alloc_fail <= 1'b0;
            r_alloc_id   <= 6'd0;
            r_free_err   <= 1'b0;
        end else begin
            r_occ        <= w_occ_nxt;
            r_free_count <= w_count_nxt;
            r_full       <= (w_count_nxt == 6'd0);
            r_empty      <= (w_count_nxt == c_none);
            r_alloc_gnt  <= w_gnt;
            r_alloc_fail <= w_fail;
            r_free_err   <= w_free_err;
            if (alloc_req) begin
                r_alloc_id <= w_search;
            end
        end
    end

    assign occupancy  = r_occ;
    assign free_count = r_free_count;
    assign full       = r_full;
    assign empty      = r_empty;
    assign alloc_gnt  = r_alloc_gnt;
    assign alloc_fail = r_alloc_fail;
    assign alloc_id   = r_alloc_id;
    assign free_err   = r_free_err;

endmodule
`default_nettype wire
